// File: rtl/motor_pwm_drv.sv
// Dual H-bridge driver: registers the wheel command word, ramps each wheel's duty,
// inserts decel + dead time before reversals and generates edge-aligned PWM.
`timescale 1ns/1ps

module motor_pwm_chan #(
    parameter int PWM_PERIOD  = 100,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       tick,
    input  logic       period_end,
    input  logic [6:0] cnt,
    input  logic       dir,
    input  logic [6:0] spd,
    output logic       pwm,
    output logic [1:0] in_pins,
    output logic [6:0] duty,
    output logic [1:0] state
);

    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [6:0] MAX_DUTY = 7'(PWM_PERIOD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DECEL = 2'd2,
        DEAD  = 2'd3
    } state_t;

    state_t        st;
    logic          dir_q;
    logic [DW-1:0] dead_cnt;
    logic [6:0]    cmp;
    logic [6:0]    target;

    assign target = (spd > MAX_DUTY) ? MAX_DUTY : spd;

    // Direction checks take priority over speed changes; a tick that coincides
    // with a state change is deliberately not applied on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            dir_q    <= 1'b1;
            duty     <= '0;
            in_pins  <= 2'b00;
            dead_cnt <= '0;
            cmp      <= '0;
        end else if (!enable) begin
            st       <= IDLE;
            duty     <= '0;
            in_pins  <= 2'b00;
            dead_cnt <= '0;
            cmp      <= '0;
        end else begin
            if (period_end)
                cmp <= duty;
            case (st)
                IDLE: begin
                    in_pins <= 2'b00;
                    duty    <= '0;
                    if (target != 7'd0) begin
                        st      <= RUN;
                        dir_q   <= dir;
                        in_pins <= dir ? 2'b10 : 2'b01;
                    end
                end
                RUN: begin
                    if (dir != dir_q) begin
                        if (duty != 7'd0) begin
                            st <= DECEL;
                        end else begin
                            st       <= DEAD;
                            in_pins  <= 2'b00;
                            dead_cnt <= '0;
                        end
                    end else if (target == 7'd0 && duty == 7'd0) begin
                        st      <= IDLE;
                        in_pins <= 2'b00;
                    end else if (tick) begin
                        if (duty < target)
                            duty <= duty + 7'd1;
                        else if (duty > target)
                            duty <= duty - 7'd1;
                    end
                end
                DECEL: begin
                    if (dir == dir_q) begin
                        st <= RUN;
                    end else if (duty == 7'd0) begin
                        st       <= DEAD;
                        in_pins  <= 2'b00;
                        dead_cnt <= '0;
                    end else if (tick) begin
                        duty <= duty - 7'd1;
                    end
                end
                DEAD: begin
                    in_pins <= 2'b00;
                    duty    <= '0;
                    if (dead_cnt == DEAD_LAST)
                        st <= IDLE;
                    else
                        dead_cnt <= dead_cnt + DW'(1);
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign pwm   = (cnt < cmp);
    assign state = st;

endmodule

module motor_pwm_drv #(
    parameter int PWM_PERIOD  = 100,
    parameter int RAMP_DIV    = 5000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] car_speed,
    input  logic        enable,
    output logic        pwm_l,
    output logic        pwm_r,
    output logic [1:0]  in_l,
    output logic [1:0]  in_r,
    output logic [6:0]  duty_l,
    output logic [6:0]  duty_r,
    output logic [1:0]  state_l,
    output logic [1:0]  state_r
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);
    localparam logic [6:0] CNT_LAST = 7'(PWM_PERIOD - 1);

    logic [15:0]   cmd_q;
    logic [PW-1:0] presc;
    logic [6:0]    cnt;
    logic          tick;
    logic          period_end;

    // Command register plus the free-running ramp prescaler and PWM counter,
    // which keep counting even while enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= '0;
            presc <= '0;
            cnt   <= '0;
        end else begin
            cmd_q <= car_speed;
            presc <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
            cnt   <= (cnt == CNT_LAST) ? '0 : cnt + 7'd1;
        end
    end

    assign tick       = (presc == PRE_LAST);
    assign period_end = (cnt == CNT_LAST);

    motor_pwm_chan #(
        .PWM_PERIOD (PWM_PERIOD),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_left (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .tick      (tick),
        .period_end(period_end),
        .cnt       (cnt),
        .dir       (cmd_q[15]),
        .spd       (cmd_q[14:8]),
        .pwm       (pwm_l),
        .in_pins   (in_l),
        .duty      (duty_l),
        .state     (state_l)
    );

    motor_pwm_chan #(
        .PWM_PERIOD (PWM_PERIOD),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_right (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .tick      (tick),
        .period_end(period_end),
        .cnt       (cnt),
        .dir       (cmd_q[7]),
        .spd       (cmd_q[6:0]),
        .pwm       (pwm_r),
        .in_pins   (in_r),
        .duty      (duty_r),
        .state     (state_r)
    );

endmodule

// File: tb/tb_motor_pwm_drv.sv
// Scoreboard bench for motor_pwm_drv: every change of a wheel's {state,in,duty}
// is popped against a queue of hand-computed expected values.
`timescale 1ns/1ps

module tb_motor_pwm_drv;

    localparam int PWM_PERIOD  = 10;
    localparam int RAMP_DIV    = 4;
    localparam int DEAD_CYCLES = 8;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DECEL = 2'd2, S_DEAD = 2'd3;
    localparam logic [1:0] P_OFF = 2'b00, P_FWD = 2'b10, P_REV = 2'b01;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] car_speed = 16'h8585;
    logic        enable = 1'b1;
    logic        pwm_l, pwm_r;
    logic [1:0]  in_l, in_r;
    logic [6:0]  duty_l, duty_r;
    logic [1:0]  state_l, state_r;

    int vectors = 0;
    int errors  = 0;

    logic [10:0] q_l[$];
    logic [10:0] q_r[$];
    logic [10:0] prev_l = '0, prev_r = '0;
    logic [10:0] cur_l, cur_r, exp_l, exp_r;

    motor_pwm_drv #(
        .PWM_PERIOD (PWM_PERIOD),
        .RAMP_DIV   (RAMP_DIV),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .car_speed(car_speed),
        .enable   (enable),
        .pwm_l    (pwm_l),
        .pwm_r    (pwm_r),
        .in_l     (in_l),
        .in_r     (in_r),
        .duty_l   (duty_l),
        .duty_r   (duty_r),
        .state_l  (state_l),
        .state_r  (state_r)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] cs, input logic en);
        car_speed = cs;
        enable    = en;
    endtask

    task automatic pushEvent(input bit left, input logic [1:0] s, input logic [1:0] p, input int d);
        if (left)
            q_l.push_back({s, p, 7'(d)});
        else
            q_r.push_back({s, p, 7'(d)});
    endtask

    task automatic pushRamp(input bit left, input logic [1:0] s, input logic [1:0] p, input int from, input int to);
        int d;
        d = from;
        pushEvent(left, s, p, d);
        while (d != to) begin
            d = (to > from) ? d + 1 : d - 1;
            pushEvent(left, s, p, d);
        end
    endtask

    task automatic countHigh(output int nl, output int nr);
        nl = 0;
        nr = 0;
        repeat (PWM_PERIOD) begin
            @(negedge clk);
            nl += int'(pwm_l);
            nr += int'(pwm_r);
        end
    endtask

    // Monitor: each observed change of a wheel's output bundle consumes one expectation.
    always @(negedge clk) begin
        cur_l = {state_l, in_l, duty_l};
        cur_r = {state_r, in_r, duty_r};
        if (cur_l !== prev_l) begin
            if (q_l.size() == 0) begin
                checkOutput("left unexpected event", 32'(cur_l), 32'(prev_l));
            end else begin
                exp_l = q_l.pop_front();
                checkOutput("left event", 32'(cur_l), 32'(exp_l));
            end
            prev_l = cur_l;
        end
        if (cur_r !== prev_r) begin
            if (q_r.size() == 0) begin
                checkOutput("right unexpected event", 32'(cur_r), 32'(prev_r));
            end else begin
                exp_r = q_r.pop_front();
                checkOutput("right event", 32'(cur_r), 32'(exp_r));
            end
            prev_r = cur_r;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int nl, nr, n, dead, bad_in;

        // Reset with both wheels commanded forward at speed 5
        applyStimulus(16'h8585, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("outputs in reset",
                    32'({pwm_l, pwm_r, in_l, in_r, duty_l, duty_r, state_l, state_r}), 32'h0);
        pushRamp(1, S_RUN, P_FWD, 0, 5);
        pushRamp(0, S_RUN, P_FWD, 0, 5);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 checkOutput("in_l after edge 1", 32'(in_l), 32'h0);
        @(posedge clk); #1 checkOutput("in_l after edge 2", 32'(in_l), 32'h2);
        checkOutput("in_r after edge 2", 32'(in_r), 32'h2);
        repeat (17) @(posedge clk);
        #1 checkOutput("duty_l at edge 19", 32'(duty_l), 32'd4);
        @(posedge clk); #1 checkOutput("duty_l at edge 20", 32'(duty_l), 32'd5);
        checkOutput("duty_r at edge 20", 32'(duty_r), 32'd5);
        repeat (20) @(negedge clk);
        countHigh(nl, nr);
        checkOutput("pwm_l high count duty 5", 32'(nl), 32'd5);
        checkOutput("pwm_r high count duty 5", 32'(nr), 32'd5);

        // Over-range speed clamps at full duty, then ramp back to stop
        @(negedge clk);
        pushRamp(1, S_RUN, P_FWD, 6, 10);
        pushRamp(0, S_RUN, P_FWD, 6, 10);
        applyStimulus(16'hFFFF, 1'b1);
        repeat (60) @(negedge clk);
        checkOutput("duty_l clamped", 32'(duty_l), 32'd10);
        countHigh(nl, nr);
        checkOutput("pwm_l high count duty 10", 32'(nl), 32'd10);
        checkOutput("pwm_r high count duty 10", 32'(nr), 32'd10);
        pushRamp(1, S_RUN, P_FWD, 9, 0);
        pushRamp(0, S_RUN, P_FWD, 9, 0);
        pushEvent(1, S_IDLE, P_OFF, 0);
        pushEvent(0, S_IDLE, P_OFF, 0);
        applyStimulus(16'h8080, 1'b1);
        repeat (70) @(negedge clk);
        checkOutput("state_l idle after stop", 32'(state_l), 32'(S_IDLE));
        countHigh(nl, nr);
        checkOutput("pwm_l high count stopped", 32'(nl), 32'd0);
        checkOutput("pwm_r high count stopped", 32'(nr), 32'd0);

        // Back to forward 5, then abort a reversal halfway through decel
        pushRamp(1, S_RUN, P_FWD, 0, 5);
        pushRamp(0, S_RUN, P_FWD, 0, 5);
        applyStimulus(16'h8585, 1'b1);
        repeat (40) @(negedge clk);
        pushRamp(1, S_DECEL, P_FWD, 5, 3);
        applyStimulus(16'h0585, 1'b1);
        n = 0;
        while (!(state_l == S_DECEL && duty_l == 7'd3) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach decel duty 3 in time", 32'(n < 60), 32'd1);
        pushRamp(1, S_RUN, P_FWD, 3, 5);
        applyStimulus(16'h8585, 1'b1);
        repeat (30) @(negedge clk);
        checkOutput("state_l run after abort", 32'(state_l), 32'(S_RUN));
        checkOutput("duty_l restored", 32'(duty_l), 32'd5);

        // Full reversal of the left wheel: decel, dead time, reverse ramp
        pushRamp(1, S_DECEL, P_FWD, 5, 0);
        pushEvent(1, S_DEAD, P_OFF, 0);
        pushEvent(1, S_IDLE, P_OFF, 0);
        pushRamp(1, S_RUN, P_REV, 0, 5);
        applyStimulus(16'h0585, 1'b1);
        dead = 0;
        bad_in = 0;
        repeat (120) begin
            @(negedge clk);
            if (state_l == S_DEAD) begin
                dead++;
                if (in_l != P_OFF) bad_in++;
            end
        end
        checkOutput("dead phase length", 32'(dead), 32'd8);
        checkOutput("in_l nonzero during dead", 32'(bad_in), 32'd0);
        checkOutput("in_l reverse", 32'(in_l), 32'h1);
        checkOutput("duty_l reverse ramp", 32'(duty_l), 32'd5);
        checkOutput("right wheel untouched", 32'({in_r, duty_r}), 32'({P_FWD, 7'd5}));

        // Emergency stop and restart
        pushEvent(1, S_IDLE, P_OFF, 0);
        pushEvent(0, S_IDLE, P_OFF, 0);
        applyStimulus(16'h0585, 1'b0);
        @(posedge clk);
        #1 checkOutput("outputs after enable low",
                       32'({pwm_l, pwm_r, in_l, in_r, duty_l, duty_r, state_l, state_r}), 32'h0);
        repeat (5) @(negedge clk);
        checkOutput("pwm stays low while disabled", 32'({pwm_l, pwm_r}), 32'h0);
        pushRamp(1, S_RUN, P_REV, 0, 5);
        pushRamp(0, S_RUN, P_FWD, 0, 5);
        applyStimulus(16'h0585, 1'b1);
        repeat (40) @(negedge clk);
        checkOutput("duty_l after re-enable", 32'(duty_l), 32'd5);

        // Asynchronous reset in the middle of a dead phase
        pushRamp(1, S_DECEL, P_REV, 5, 0);
        pushEvent(1, S_DEAD, P_OFF, 0);
        pushEvent(1, S_IDLE, P_OFF, 0);
        pushEvent(0, S_IDLE, P_OFF, 0);
        applyStimulus(16'h8585, 1'b1);
        n = 0;
        while (state_l != S_DEAD && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach dead in time", 32'(n < 60), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("outputs after async reset",
                       32'({pwm_l, pwm_r, in_l, in_r, duty_l, duty_r, state_l, state_r}), 32'h0);
        pushRamp(1, S_RUN, P_FWD, 0, 5);
        pushRamp(0, S_RUN, P_FWD, 0, 5);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1 checkOutput("in_l edge 1 after reset", 32'(in_l), 32'h0);
        @(posedge clk); #1 checkOutput("in_l edge 2 after reset", 32'(in_l), 32'h2);
        checkOutput("state_l run after reset", 32'(state_l), 32'(S_RUN));
        repeat (40) @(negedge clk);
        checkOutput("duty_l fresh ramp", 32'(duty_l), 32'd5);

        n = 0;
        while ((q_l.size() != 0 || q_r.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard entries left", 32'(q_l.size() + q_r.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
